mssd_frame_scheduler: RTL and testbench
=======================================

Name: mssd_frame_scheduler

Overview:
- Round-robin transmit scheduler that shares one serial line among 4 requesters.
- Serializes each granted request into a frame: start bit, 2-bit destination, length field, payload.
- Frames drive the serial input of the serial demultiplexer; the line idles high between frames.
- Lets 4 producers target demux ports p0..p3 without colliding on the line.

Parameters:
- LEN_W, 4, width of the length field; max payload MAX_LEN = 2**LEN_W-1 bits (15).
- GAP_CYC, 2, idle-high cycles inserted after every frame; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- req  input  4  req[i]=1: requester i has a frame pending
- req_dest  input  8  {dest3,dest2,dest1,dest0}, 2 bits per requester, destination port 0..3
- req_len  input  4*LEN_W  per-requester payload length, slice i = [i*LEN_W +: LEN_W]
- req_data  input  4*MAX_LEN  per-requester payload, slice i, bit 0 sent first
- gnt  output  4  one-hot, 1-cycle pulse: request i accepted and fields latched
- done  output  4  one-hot, 1-cycle pulse: frame of requester i fully sent
- serOut  output  1  serial line to demux
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, serOut=1, gnt=0, done=0, busy=0, RR pointer=0 (requester 0 highest). Reset mid-frame aborts the frame; serOut returns to 1 immediately; no done pulse.
- FSM states: IDLE, START, DEST, LEN, DATA, GAP (PAR with the optional feature).
- IDLE: serOut=1. At an edge with req!=0, latch winner's dest/len/data, go to START. gnt[winner]=1 for exactly that next cycle (registered).
- Arbitration: search starts at pointer p, cycles p, p+1, ... mod 4. After a grant to i, p=(i+1) mod 4. With no grant, p is held.
- START: 1 cycle, serOut=0.
- DEST: 2 cycles, dest MSB first.
- LEN: LEN_W cycles, length MSB first.
- DATA: L cycles (L = latched length), payload bit 0 first, bits [L-1:0] only. L=0 skips DATA (LEN goes straight to GAP/PAR).
- GAP: GAP_CYC cycles, serOut=1. On the last GAP cycle done[i]=1, then IDLE.
- Frame length: 1+2+LEN_W+L(+1) cycles plus GAP_CYC. Back-to-back start bits are therefore 7+L+GAP_CYC+1 cycles apart (default, no parity); the extra cycle is the IDLE arbitration cycle.
- Input handshake: requester holds req plus fields until gnt. Fields are latched at grant, so inputs may change afterward. req still 1 after done counts as a new request.
- req changes during a frame are ignored until IDLE.
- Simultaneous events: all 4 req rising at once are granted in pointer order. A requester is never granted twice while another is waiting.
- Counters: one bit counter (width max(LEN_W,4)) reloaded at each state entry. No wrap beyond terminal count.
- gnt and done are never both nonzero in the same cycle.

Optional Feature:
- Macro MSSD_SCHED_PARITY_EN.
- Defined: PAR state after DATA (or after LEN when L=0) sends one even-parity bit over dest, len and payload bits, so the total count of 1s is even. Frames are 1 cycle longer.
- Undefined: no PAR state; LEN/DATA go directly to GAP.

Test Plan:
- Reset: rst=0 mid-DATA -> serOut=1, busy=0, gnt=done=0 within the same cycle. After release, pointer=0.
- Single frame: req[2]=1, dest=2'b01, len=4'd3, data=3'b101 -> gnt[2] 1 cycle later. serOut = 0,0,1,0,0,1,1,1,0,1,1,1. done[2] on the last gap cycle. busy high for 12 cycles.
- Zero length: req[0], dest=3, len=0 -> serOut = 0,1,1,0,0,0,0,1,1. No data bits; done[0] pulses.
- Round-robin: req=4'b1111 held continuously -> gnt order 0,1,2,3,0. No overlap between frames; each gap is at least GAP_CYC high cycles.
- Fairness: req[0] held, req[3] asserted during frame 0 -> next gnt goes to 3, not 0.
- Parity (MSSD_SCHED_PARITY_EN): dest=1, len=3, data=3'b101 -> parity bit 1 (five 1s) after the data bits. Frame is 13 cycles with busy high.

Source files
------------

// File: rtl/mssd_frame_scheduler_if.sv
// Request/grant bus and serial output of the 4-requester frame scheduler.
// The master drives requests and payload fields; the slave is the scheduler.
interface mssd_frame_scheduler_if #(
  parameter int LEN_W = 4
);
  localparam int MAX_LEN = 2**LEN_W - 1;

  logic [3:0]           req;
  logic [7:0]           req_dest;
  logic [4*LEN_W-1:0]   req_len;
  logic [4*MAX_LEN-1:0] req_data;
  logic [3:0]           gnt;
  logic [3:0]           done;
  logic                 serOut;
  logic                 busy;

  modport master (
    output req, req_dest, req_len, req_data,
    input  gnt, done, serOut, busy
  );

  modport slave (
    input  req, req_dest, req_len, req_data,
    output gnt, done, serOut, busy
  );
endinterface

// File: rtl/mssd_frame_scheduler.sv
// Round-robin scheduler serializing start/dest/len/payload frames onto one line.
// Optional MSSD_SCHED_PARITY_EN adds an even-parity bit before the idle gap.
module mssd_frame_scheduler #(
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mssd_frame_scheduler_if.slave  bus
);
  localparam int MAX_LEN = 2**LEN_W - 1;
  localparam int CW      = (LEN_W > 4) ? LEN_W : 4;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] LEN_LAST = CW'(LEN_W - 1);

`ifdef MSSD_SCHED_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DEST, LEN, DATA, PAR, GAP} state_t;
  localparam state_t POST_DATA = PAR;
`else
  typedef enum logic [2:0] {IDLE, START, DEST, LEN, DATA, GAP} state_t;
  localparam state_t POST_DATA = GAP;
`endif

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           own_q, own_d;
  logic [1:0]           dest_q, dest_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [3:0]           gnt_q, gnt_d;

  logic                 found;
  logic [1:0]           win;
  logic [1:0]           arb_idx;
  logic [1:0]           win_dest;
  logic [LEN_W-1:0]     win_len;
  logic [MAX_LEN-1:0]   win_data;
  logic                 ser;

  // First pending requester at or after the pointer, wrapping mod 4.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    arb_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      arb_idx = ptr_q + 2'(k);
      if (!found && bus.req[arb_idx]) begin
        found = 1'b1;
        win   = arb_idx;
      end
    end
  end

  always_comb begin
    win_dest = '0;
    win_len  = '0;
    win_data = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (win == 2'(k)) begin
        win_dest = bus.req_dest[2*k +: 2];
        win_len  = bus.req_len[k*LEN_W +: LEN_W];
        win_data = bus.req_data[k*MAX_LEN +: MAX_LEN];
      end
    end
`ifdef MSSD_SCHED_PARITY_EN
    // Bits above the length never reach the line, so keep them out of the parity.
    win_data = win_data & ({MAX_LEN{1'b1}} >> (MAX_LEN - int'(win_len)));
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    dest_d  = dest_q;
    len_d   = len_q;
    data_d  = data_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = START;
          own_d   = win;
          ptr_d   = win + 2'd1;
          dest_d  = win_dest;
          len_d   = win_len;
          data_d  = win_data;
          gnt_d   = 4'b0001 << win;
        end
      end
      START: begin
        state_d = DEST;
        cnt_d   = CW'(1);
      end
      DEST: begin
        if (cnt_q == '0) begin
          state_d = LEN;
          cnt_d   = LEN_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LEN: begin
        if (cnt_q == '0) begin
          if (len_q != '0) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = POST_DATA;
            cnt_d   = GAP_LAST;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        // Counts up so the counter doubles as the payload bit index.
        if (cnt_q == CW'(len_q) - CW'(1)) begin
          state_d = POST_DATA;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef MSSD_SCHED_PARITY_EN
      PAR: begin
        state_d = GAP;
        cnt_d   = GAP_LAST;
      end
`endif
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ser = 1'b1;
    case (state_q)
      START: ser = 1'b0;
      DEST:  ser = 1'(dest_q >> cnt_q);
      LEN:   ser = 1'(len_q >> cnt_q);
      DATA:  ser = 1'(data_q >> cnt_q);
`ifdef MSSD_SCHED_PARITY_EN
      PAR:   ser = ^{dest_q, len_q, data_q};
`endif
      default: ser = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      dest_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.serOut = ser;
  assign bus.busy   = (state_q != IDLE);
  assign bus.gnt    = gnt_q;
  assign bus.done   = (state_q == GAP && cnt_q == '0) ? (4'b0001 << own_q) : '0;
endmodule

// File: tb/tb_mssd_frame_scheduler.sv
// Bench for mssd_frame_scheduler: queue-based frame model checked every cycle,
// plus directed frames with hand-computed serial traces.
module tb_mssd_frame_scheduler;
  localparam int LEN_W   = 4;
  localparam int MAX_LEN = 15;
  localparam int GAP_CYC = 2;
`ifdef MSSD_SCHED_PARITY_EN
  localparam int PB = 1;
  localparam logic [31:0] TRACE_SINGLE = 32'h1EE4;
  localparam logic [31:0] TRACE_ZERO   = 32'h306;
`else
  localparam int PB = 0;
  localparam logic [31:0] TRACE_SINGLE = 32'hEE4;
  localparam logic [31:0] TRACE_ZERO   = 32'h186;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mssd_frame_scheduler_if #(.LEN_W(LEN_W)) bus();

  mssd_frame_scheduler #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each frame is the list of line values it must produce, one per cycle.
  bit m_q[$];
  int m_pos = 0;
  int m_own = 0;
  int m_ptr = 0;

  function automatic int pick();
    int w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && bus.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    return w;
  endfunction

  function automatic void start_frame(input int w);
    logic [1:0]         d;
    logic [LEN_W-1:0]   l;
    logic [MAX_LEN-1:0] p;
    int ones;
    d = bus.req_dest[2*w +: 2];
    l = bus.req_len[w*LEN_W +: LEN_W];
    p = bus.req_data[w*MAX_LEN +: MAX_LEN];
    m_q.delete();
    m_q.push_back(1'b0);
    m_q.push_back(d[1]);
    m_q.push_back(d[0]);
    for (int b = LEN_W - 1; b >= 0; b--) m_q.push_back(l[b]);
    for (int b = 0; b < int'(l); b++) m_q.push_back(p[b]);
    ones = 0;
    foreach (m_q[i]) ones += int'(m_q[i]);
`ifdef MSSD_SCHED_PARITY_EN
    m_q.push_back(bit'(ones % 2));
`endif
    for (int g = 0; g < GAP_CYC; g++) m_q.push_back(1'b1);
    m_own = w;
    m_pos = 0;
    m_ptr = (w + 1) % 4;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_pos = 0;
      m_ptr = 0;
    end else if (m_q.size() != 0) begin
      m_pos++;
      if (m_pos >= m_q.size()) begin
        m_q.delete();
        m_pos = 0;
      end
    end else if (bus.req != 4'b0000) begin
      start_frame(pick());
    end
  end

  function automatic logic [31:0] model_out();
    logic       s, b;
    logic [3:0] g, dn;
    s = 1'b1; b = 1'b0; g = 4'b0000; dn = 4'b0000;
    if (m_q.size() != 0) begin
      s = m_q[m_pos];
      b = 1'b1;
      if (m_pos == 0) g = 4'b0001 << m_own;
      if (m_pos == m_q.size() - 1) dn = 4'b0001 << m_own;
    end
    return {22'd0, s, b, g, dn};
  endfunction

  always @(negedge clk) begin
    chk("line{ser,busy,gnt,done}", {22'd0, bus.serOut, bus.busy, bus.gnt, bus.done}, model_out());
  end

  task automatic set_fields(input int i, input logic [1:0] d, input logic [LEN_W-1:0] l,
                            input logic [MAX_LEN-1:0] p);
    bus.req_dest[2*i +: 2]             = d;
    bus.req_len[i*LEN_W +: LEN_W]      = l;
    bus.req_data[i*MAX_LEN +: MAX_LEN] = p;
  endtask

  task automatic wait_gnt(output int w);
    w = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      w++;
      if (bus.gnt != 4'b0000) break;
    end
    n_checks++;
    if (bus.gnt == 4'b0000) begin
      n_errors++;
      $display("FAIL gnt_wait: got no grant after %0d cycles, required a grant", w);
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("idle_wait", 32'(bus.busy), 32'd0);
  endtask

  task automatic capture(input int n, output logic [31:0] tr, output int nbusy,
                         output int didx, output logic [3:0] dval,
                         output logic [3:0] g, output int wcyc);
    wait_gnt(wcyc);
    g = bus.gnt;
    bus.req = 4'b0000;
    tr = '0; nbusy = 0; didx = -1; dval = 4'b0000;
    for (int i = 0; i < n + 3; i++) begin
      if (i > 0) @(negedge clk);
      if (i < n) tr[i] = bus.serOut;
      if (bus.busy) nbusy++;
      if (bus.done != 4'b0000) begin
        didx = i;
        dval = bus.done;
      end
    end
  endtask

  initial begin
    logic [31:0] tr;
    logic [3:0]  g, dv;
    logic [19:0] order;
    int nb, di, wc, ng;

    bus.req = '0; bus.req_dest = '0; bus.req_len = '0; bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_ser", 32'(bus.serOut), 32'd1);
    chk("reset_gnt_done", {24'd0, bus.gnt, bus.done}, 32'd0);
    rst = 1'b1;

    // Single frame: dest 1, len 3, payload 101.
    @(posedge clk); #1;
    set_fields(2, 2'b01, 4'd3, 15'b101);
    bus.req = 4'b0100;
    capture(12 + PB, tr, nb, di, dv, g, wc);
    chk("single_gnt_latency", 32'(wc), 32'd2);
    chk("single_gnt", 32'(g), 32'h4);
    chk("single_trace", tr, TRACE_SINGLE);
    chk("single_busy_cycles", 32'(nb), 32'(12 + PB));
    chk("single_done_cycle", 32'(di), 32'(11 + PB));
    chk("single_done", 32'(dv), 32'h4);

    // Zero length: no payload bits.
    set_fields(0, 2'b11, 4'd0, 15'h7FFF);
    bus.req = 4'b0001;
    capture(9 + PB, tr, nb, di, dv, g, wc);
    chk("zero_gnt", 32'(g), 32'h1);
    chk("zero_trace", tr, TRACE_ZERO);
    chk("zero_busy_cycles", 32'(nb), 32'(9 + PB));
    chk("zero_done_cycle", 32'(di), 32'(8 + PB));
    chk("zero_done", 32'(dv), 32'h1);

    // Reset in the middle of the payload.
    set_fields(1, 2'b10, 4'd8, 15'h00AB);
    bus.req = 4'b0010;
    wait_gnt(wc);
    chk("mid_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    repeat (9) @(negedge clk);
    chk("mid_busy_before_reset", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_ser", 32'(bus.serOut), 32'd1);
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_reset_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // All four requesting: pointer restarts at 0 after reset.
    for (int i = 0; i < 4; i++) set_fields(i, 2'(i), 4'(i + 1), 15'h5A5A ^ 15'(i));
    bus.req = 4'b1111;
    order = '0; ng = 0;
    for (int t = 0; t < 300 && ng < 5; t++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) begin
        order[4*ng +: 4] = bus.gnt;
        ng++;
        if (ng == 5) bus.req = 4'b0000;
      end
    end
    chk("rr_grant_count", 32'(ng), 32'd5);
    chk("rr_order", 32'(order), 32'h18421);
    wait_idle();

    // Fairness: requester 3 arrives while 0 is being served and keeps requesting.
    bus.req = 4'b0001;
    wait_gnt(wc);
    chk("fair_first", 32'(bus.gnt), 32'h1);
    bus.req = 4'b1001;
    wait_gnt(wc);
    chk("fair_second", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000;
    wait_idle();

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
